// File: rtl/sample_pacer_pkg.sv
// ============================================================================
// Module  : sample_pacer_pkg
// Brief   : Shared pacing FSM state type and default sizing for sample_pacer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sample_pacer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int c_default_dw          = 16;
    localparam int c_default_depth       = 8;
    localparam int c_default_prime_level = 4;

endpackage : sample_pacer_pkg

`default_nettype wire

// File: rtl/sample_pacer_sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO with occupancy count; head is visible on rdata.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_level == c_LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign rdata     = r_mem[r_rd_ptr];
    // Guard against misuse so pointers can never run past each other.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/sample_pacer.sv
// ============================================================================
// Module  : sample_pacer
// Brief   : Buffers upstream samples and releases them at a programmable rate.
//           Define SAMPLE_PACER_HOLD_EN to hold the last sample on underrun.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_pacer
    import sample_pacer_pkg::*;
#(
    parameter int DW          = c_default_dw,
    parameter int DEPTH       = c_default_depth,
    parameter int PRIME_LEVEL = c_default_prime_level
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [15:0]             rate_div,
    input  logic signed [DW-1:0]    in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [DW-1:0]    x,
    output logic                    x_tick,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    underrun,
    input  logic                    clr_underrun
);

    localparam int c_LW = $clog2(DEPTH) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_cnt;
    logic            w_tick;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [DW-1:0]   w_head;

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;
    // Live compare so a shrinking rate_div fires on the very next clock.
    assign w_tick   = (r_state == RUN) && (r_cnt >= rate_div);
    assign w_pop    = w_tick && !w_empty;

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = PRIME;
                PRIME:   if (level >= c_LW'(PRIME_LEVEL)) w_state_nxt = RUN;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != RUN)) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x        <= '0;
            x_tick   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            x_tick <= w_tick;
            if (w_tick) begin
                if (!w_empty) begin
                    x <= $signed(w_head);
                end else begin
`ifdef SAMPLE_PACER_HOLD_EN
                    x <= x;
`else
                    x <= '0;
`endif
                end
            end
            // A fresh underrun outranks a simultaneous clear.
            if (w_tick && w_empty) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule : sample_pacer

`default_nettype wire

// File: doc/sample_pacer.md
SAMPLE_PACER -- requirements
Module: sample_pacer

Interface
REQ-001 Parameter DW, default 16, sample width in bits (two's complement).
REQ-002 Parameter DEPTH, default 8, FIFO depth in samples; power of two, at least 2.
REQ-003 Parameter PRIME_LEVEL, default 4, FIFO fill level required to start pacing; range 1..DEPTH.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  pacing enable.
REQ-007 rate_div  in  16  tick period minus one, in clocks.
REQ-008 in_data  in  DW  signed upstream sample.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  FIFO can accept a sample.
REQ-011 x  out  DW  signed sample presented to the downstream IIR stage.
REQ-012 x_tick  out  1  one-clock strobe: x updated this cycle.
REQ-013 level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-014 underrun  out  1  sticky flag: a tick occurred with the FIFO empty.
REQ-015 clr_underrun  in  1  clears underrun.

Function
REQ-016 in_ready SHALL equal (level != DEPTH), combinational from level.
REQ-017 A push SHALL occur on a clock where in_valid && in_ready; in_data is written at the tail.
REQ-018 States: IDLE, PRIME, RUN.
REQ-019 IDLE->PRIME when enable=1; PRIME->RUN when enable=1 and level >= PRIME_LEVEL; any state->IDLE when enable=0.
REQ-020 In IDLE and PRIME: no ticks, rate counter held at 0, FIFO still accepts pushes.
REQ-021 In RUN: rate counter increments every clock; tick condition is cnt >= rate_div (live value); on tick cnt <= 0.
REQ-022 rate_div=0 SHALL tick every clock; reducing rate_div mid-run below cnt SHALL tick on the next clock.
REQ-023 On tick with FIFO non-empty: pop the head; x <= head and x_tick <= 1 on the following edge (latency 1 clock from tick condition).
REQ-024 On tick with FIFO empty: underrun <= 1; x_tick still pulses (the filter's sample rate is preserved); x <= 0.
REQ-025 RUN SHALL remain RUN after an underrun; it does not re-prime.
REQ-026 Push and pop in the same clock: both take effect; level unchanged.
REQ-027 Push into an empty FIFO on a tick clock: the pop does not see the new sample; underrun is flagged and level becomes 1.
REQ-028 When full, in_ready=0 even if a pop occurs that cycle (no push-through).
REQ-029 clr_underrun and a new underrun in the same clock: set wins.
REQ-030 x_tick SHALL be 0 on every clock without a preceding tick condition; x holds its value between ticks.

Reset
REQ-031 rst=1: state IDLE, cnt 0, FIFO empty (level 0), x 0, x_tick 0, underrun 0; in_ready becomes 1 after the reset edge.
REQ-032 Reset mid-operation SHALL discard FIFO contents; no x_tick during or on the clock after reset.

Configuration
REQ-033 Macro SAMPLE_PACER_HOLD_EN: when defined, an underrun tick SHALL leave x at its previous value (hold last sample) instead of 0; x_tick and underrun behave identically.
REQ-034 Without SAMPLE_PACER_HOLD_EN, underrun SHALL drive x to 0 per REQ-024.

Structure
REQ-035 Package sample_pacer_pkg: state enum (IDLE, PRIME, RUN), default DW/DEPTH/PRIME_LEVEL constants.
REQ-036 One sub-module, sync_fifo (parameters DW, DEPTH; push/pop/full/empty/level), instantiated once; pacing FSM and counter live in sample_pacer.

Verification
REQ-037 Reset, enable=1, push 3 samples (PRIME_LEVEL=4) -> state PRIME, no x_tick; push 4th -> RUN next clock.
REQ-038 RUN, rate_div=3, FIFO holding 100,-200,300 -> x_tick every 4 clocks; x = 100, -200, 300 in order; level decrements per tick.
REQ-039 Empty FIFO in RUN, rate_div=1 -> x_tick continues, x=0 (or held at 300 with SAMPLE_PACER_HOLD_EN), underrun=1; clr_underrun -> 0.
REQ-040 enable=0, push 8 samples -> level=8, in_ready=0; 9th in_valid is ignored; one pop frees a slot the following cycle.
REQ-041 rate_div=0 with continuous in_valid -> x_tick every clock, level constant, no underrun after priming.
REQ-042 rst asserted while level=5 in RUN -> level 0, x 0, x_tick 0, state IDLE next clock.
